// File: rtl/ble_cfg_pkg.sv
// rtl/ble_cfg_pkg.sv - configuration layout shared by the fracturable BLE.
// Mode-bit offsets are relative to the end of the 2**K-bit truth table.
package ble_cfg_pkg;

   localparam int OFS_OUT0_SEL = 0;
   localparam int OFS_OUT1_SEL = 1;
   localparam int OFS_FRAC     = 2;
   localparam int OFS_INIT     = 3;
   localparam int OFS_CE       = 4;
   localparam int NUM_MODE     = 5;

   function automatic int cfg_w(input int k);
      return (2 ** k) + NUM_MODE;
   endfunction

endpackage

// File: rtl/lut_k_mux.sv
// rtl/lut_k_mux.sv - combinational 2**K:1 truth-table mux.
module lut_k_mux #(
   parameter int K = 4
) (
   input  logic [(2**K)-1:0] tt_i,
   input  logic [K-1:0]      sel_i,
   output logic              out_o
);

   assign out_o = tt_i[sel_i];

endmodule

// File: rtl/ble_k_frac.sv
// rtl/ble_k_frac.sv - fracturable K-LUT with two user FFs; config is a chain segment.
// cfg_en freezes the user FFs and forces the outputs low while the chain shifts.
module ble_k_frac
   import ble_cfg_pkg::*;
#(
   parameter int K = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cfg_en,
   input  logic         ccff_head,
   output logic         ccff_tail,
   input  logic [K-1:0] ble_in,
   input  logic         ble_ce,
   output logic [1:0]   ble_out
);

   localparam int LUT_N = 2 ** K;
   localparam int CFG_W = cfg_w(K);

   logic [CFG_W-1:0] cfg_q, cfg_d;
   logic             ff0_q, ff0_d;
   logic             ff1_q, ff1_d;

   logic             out0_sel, out1_sel, frac_en, ff_init, ce_en;
   logic [K-1:0]     full_sel;
   logic             full_out, hi_out;
   logic             lut0, lut1;

   assign out0_sel  = cfg_q[LUT_N + OFS_OUT0_SEL];
   assign out1_sel  = cfg_q[LUT_N + OFS_OUT1_SEL];
   assign frac_en   = cfg_q[LUT_N + OFS_FRAC];
   assign ff_init   = cfg_q[LUT_N + OFS_INIT];
   assign ce_en     = cfg_q[LUT_N + OFS_CE];
   assign ccff_tail = cfg_q[0];

   // In fractured mode the full mux with a zeroed MSB serves as the lower (K-1)-LUT.
   assign full_sel = frac_en ? {1'b0, ble_in[K-2:0]} : ble_in;

   lut_k_mux #(.K(K)) u_lut_full (
      .tt_i  (cfg_q[LUT_N-1:0]),
      .sel_i (full_sel),
      .out_o (full_out)
   );

   lut_k_mux #(.K(K-1)) u_lut_hi (
      .tt_i  (cfg_q[LUT_N-1:LUT_N/2]),
      .sel_i (ble_in[K-2:0]),
      .out_o (hi_out)
   );

   assign lut0 = full_out;
   assign lut1 = frac_en ? hi_out : full_out;

   always_comb begin
      cfg_d = cfg_q;
      if (cfg_en) begin
         cfg_d = {ccff_head, cfg_q[CFG_W-1:1]};
      end
   end

   always_comb begin
      ff0_d = ff0_q;
      ff1_d = ff1_q;
      if (reset) begin
         ff0_d = ff_init;
         ff1_d = ff_init;
      end else if (!cfg_en && !(ce_en && !ble_ce)) begin
         ff0_d = lut0;
         ff1_d = lut1;
      end
   end

   // The chain is deliberately outside reset so a mid-shift reset loses no bits.
   always_ff @(posedge clk) begin
      cfg_q <= cfg_d;
      ff0_q <= ff0_d;
      ff1_q <= ff1_d;
   end

   always_comb begin
      ble_out = 2'b00;
      if (!cfg_en) begin
         ble_out[0] = out0_sel ? ff0_q : lut0;
         ble_out[1] = out1_sel ? ff1_q : lut1;
      end
   end

endmodule
